hw_accel_multi_line_buffer: RTL and testbench

Parametrised multi-line buffer feeding K×K sliding-window kernels in the hw_accel pipeline. It stores the last NUM_TAPS-1 lines of a raster pixel stream and presents NUM_TAPS vertically aligned pixels per column every accepted cycle, across CHANNELS packed channels. The line width is set at runtime on each start of frame. Border lines above the first row are zero-filled or replicated. It sits between the stream input adapter and the window/convolution stage.

---
 rtl/hw_accel_lb_pkg.sv | 35 +++
 rtl/hw_accel_multi_line_buffer_if.sv | 25 ++
 rtl/hw_accel_lb_bank.sv | 24 ++
 rtl/hw_accel_multi_line_buffer.sv | 161 ++++++++++++++++
 tb/tb_hw_accel_multi_line_buffer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hw_accel_lb_pkg.sv
// Shared widths, defaults and tap packing helper for the hw_accel multi-line buffer.
package hw_accel_lb_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 8;
  localparam int unsigned CHANNELS_DEF       = 1;
  localparam int unsigned NUM_TAPS_DEF       = 3;
  localparam int unsigned MAX_LINE_WORDS_DEF = 1024;

  function automatic int unsigned col_bits(input int unsigned max_words);
    return (max_words > 1) ? $clog2(max_words) : 1;
  endfunction

  function automatic int unsigned bank_bits(input int unsigned banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  function automatic int unsigned lines_bits(input int unsigned banks);
    return $clog2(banks + 1);
  endfunction

  function automatic int unsigned lwords_bits(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

  // LSB position of tap k inside the packed dout_taps word
  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned pix_w);
    return k * pix_w;
  endfunction

  localparam int unsigned COL_W    = col_bits(MAX_LINE_WORDS_DEF);
  localparam int unsigned BANK_W   = bank_bits(NUM_TAPS_DEF - 1);
  localparam int unsigned LINES_W  = lines_bits(NUM_TAPS_DEF - 1);
  localparam int unsigned LWORDS_W = lwords_bits(MAX_LINE_WORDS_DEF);

endpackage

// File: rtl/hw_accel_multi_line_buffer_if.sv
// Pixel-in / taps-out bundle of the multi-line buffer.
interface hw_accel_multi_line_buffer_if
  import hw_accel_lb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned CHANNELS       = CHANNELS_DEF,
  parameter int unsigned NUM_TAPS       = NUM_TAPS_DEF,
  parameter int unsigned MAX_LINE_WORDS = MAX_LINE_WORDS_DEF
);
  localparam int unsigned PIX_W = CHANNELS * DATA_WIDTH;
  localparam int unsigned LW_W  = lwords_bits(MAX_LINE_WORDS);

  logic                      sof;
  logic [LW_W-1:0]           line_words;
  logic                      en;
  logic [PIX_W-1:0]          din;
  logic [NUM_TAPS*PIX_W-1:0] dout_taps;
  logic                      dout_valid;
  logic                      dout_padded_valid;

  modport master (output sof, line_words, en, din,
                  input  dout_taps, dout_valid, dout_padded_valid);
  modport slave  (input  sof, line_words, en, din,
                  output dout_taps, dout_valid, dout_padded_valid);
endinterface

// File: rtl/hw_accel_lb_bank.sv
// Read-first simple dual-port line RAM; a same-address read returns the previous contents.
module hw_accel_lb_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/hw_accel_multi_line_buffer.sv
// Multi-line buffer presenting NUM_TAPS vertically aligned pixels per column.
// Border taps are zero unless HW_ACCEL_LB_BORDER_REPLICATE_EN replicates the topmost real line.
module hw_accel_multi_line_buffer
  import hw_accel_lb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned CHANNELS       = CHANNELS_DEF,
  parameter int unsigned NUM_TAPS       = NUM_TAPS_DEF,
  parameter int unsigned MAX_LINE_WORDS = MAX_LINE_WORDS_DEF
) (
  input logic                         clk,
  input logic                         rst,
  hw_accel_multi_line_buffer_if.slave bus
);
  localparam int unsigned M           = NUM_TAPS - 1;
  localparam int unsigned PIX_W       = CHANNELS * DATA_WIDTH;
  localparam int unsigned TAPS_W      = NUM_TAPS * PIX_W;
  localparam int unsigned COL_BITS    = col_bits(MAX_LINE_WORDS);
  localparam int unsigned BANK_BITS   = bank_bits(M);
  localparam int unsigned LINES_BITS  = lines_bits(M);
  localparam int unsigned LWORDS_BITS = lwords_bits(MAX_LINE_WORDS);

  logic [LWORDS_BITS-1:0] line_words_r_q, line_words_r_d, lw_base, lw_eff;
  logic [COL_BITS-1:0]    col_q, col_d, col_base;
  logic [BANK_BITS-1:0]   wb_q, wb_d, wb_base;
  logic [LINES_BITS-1:0]  lines_q, lines_d, lines_base;

  logic                   en_s1_q, en_s1_d, valid_s1_q, valid_s1_d, pvalid_s1_q, pvalid_s1_d;
  logic [PIX_W-1:0]       din_s1_q, din_s1_d;
  logic [BANK_BITS-1:0]   wb_s1_q, wb_s1_d;
  logic [LINES_BITS-1:0]  lines_s1_q, lines_s1_d;

  logic [TAPS_W-1:0]      dout_taps_q, dout_taps_d, taps_c;
  logic                   dout_valid_q, dout_padded_valid_q;

  logic [PIX_W-1:0]       rdata [M];
  logic [PIX_W-1:0]       raw   [NUM_TAPS];

  // Counters: sof rebases them before the en update so sof+en writes pixel (0,0)
  always_comb begin
    lw_eff = bus.line_words;
    if (bus.line_words == '0 || bus.line_words > LWORDS_BITS'(MAX_LINE_WORDS))
      lw_eff = LWORDS_BITS'(MAX_LINE_WORDS);

    lw_base    = line_words_r_q;
    col_base   = col_q;
    wb_base    = wb_q;
    lines_base = lines_q;
    if (bus.sof) begin
      lw_base    = lw_eff;
      col_base   = '0;
      wb_base    = '0;
      lines_base = '0;
    end

    line_words_r_d = lw_base;
    col_d          = col_base;
    wb_d           = wb_base;
    lines_d        = lines_base;
    if (bus.en) begin
      if (LWORDS_BITS'(col_base) == lw_base - LWORDS_BITS'(1)) begin
        col_d   = '0;
        wb_d    = (wb_base == BANK_BITS'(M - 1)) ? '0 : wb_base + BANK_BITS'(1);
        lines_d = (lines_base == LINES_BITS'(M)) ? lines_base : lines_base + LINES_BITS'(1);
      end else begin
        col_d = col_base + COL_BITS'(1);
      end
    end

    en_s1_d     = bus.en;
    din_s1_d    = bus.din;
    wb_s1_d     = wb_base;
    lines_s1_d  = lines_base;
    valid_s1_d  = bus.en && (lines_base == LINES_BITS'(M));
    pvalid_s1_d = bus.en && (lines_base >= LINES_BITS'((NUM_TAPS - 1) / 2));
  end

  for (genvar g = 0; g < M; g++) begin : g_bank
    hw_accel_lb_bank #(
      .WIDTH (PIX_W),
      .DEPTH (MAX_LINE_WORDS),
      .ADDR_W(COL_BITS)
    ) u_bank (
      .clk  (clk),
      .we   (bus.en && (wb_base == BANK_BITS'(g))),
      .waddr(col_base),
      .wdata(bus.din),
      .re   (bus.en),
      .raddr(col_base),
      .rdata(rdata[g])
    );
  end

  // Tap k comes from bank (wb - k) mod M, using wb captured with the read
  always_comb begin
    raw[0] = din_s1_q;
    for (int k = 1; k < NUM_TAPS; k++) begin
      raw[k] = '0;
      for (int b = 0; b < M; b++)
        if ((int'(wb_s1_q) + int'(M) - k) % int'(M) == b) raw[k] = rdata[b];
    end
  end

  always_comb begin
`ifdef HW_ACCEL_LB_BORDER_REPLICATE_EN
    logic [PIX_W-1:0] rep;
    rep = '0;
    for (int j = 0; j < NUM_TAPS; j++)
      if (j == int'(lines_s1_q)) rep = raw[j];
`endif
    taps_c = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (k > int'(lines_s1_q)) begin
`ifdef HW_ACCEL_LB_BORDER_REPLICATE_EN
        taps_c[tap_lsb(k, PIX_W) +: PIX_W] = rep;
`else
        taps_c[tap_lsb(k, PIX_W) +: PIX_W] = '0;
`endif
      end else begin
        taps_c[tap_lsb(k, PIX_W) +: PIX_W] = raw[k];
      end
    end
    dout_taps_d = en_s1_q ? taps_c : dout_taps_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_words_r_q      <= LWORDS_BITS'(MAX_LINE_WORDS);
      col_q               <= '0;
      wb_q                <= '0;
      lines_q             <= '0;
      en_s1_q             <= 1'b0;
      valid_s1_q          <= 1'b0;
      pvalid_s1_q         <= 1'b0;
      din_s1_q            <= '0;
      wb_s1_q             <= '0;
      lines_s1_q          <= '0;
      dout_taps_q         <= '0;
      dout_valid_q        <= 1'b0;
      dout_padded_valid_q <= 1'b0;
    end else begin
      line_words_r_q      <= line_words_r_d;
      col_q               <= col_d;
      wb_q                <= wb_d;
      lines_q             <= lines_d;
      en_s1_q             <= en_s1_d;
      valid_s1_q          <= valid_s1_d;
      pvalid_s1_q         <= pvalid_s1_d;
      din_s1_q            <= din_s1_d;
      wb_s1_q             <= wb_s1_d;
      lines_s1_q          <= lines_s1_d;
      dout_taps_q         <= dout_taps_d;
      dout_valid_q        <= valid_s1_q;
      dout_padded_valid_q <= pvalid_s1_q;
    end
  end

  assign bus.dout_taps         = dout_taps_q;
  assign bus.dout_valid        = dout_valid_q;
  assign bus.dout_padded_valid = dout_padded_valid_q;
endmodule

// File: tb/tb_hw_accel_multi_line_buffer.sv
// Bench for hw_accel_multi_line_buffer: frame model + scoreboard queue, plus a table of hand-derived taps.
module tb_hw_accel_multi_line_buffer;
  import hw_accel_lb_pkg::*;

  localparam int unsigned NT   = 3;
  localparam int unsigned MM   = NT - 1;
  localparam int unsigned PW   = 8;
  localparam int unsigned TW   = NT * PW;
  localparam int unsigned MAXW = 1024;
`ifdef HW_ACCEL_LB_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    bit            active;
    logic [TW-1:0] taps;
    bit            v;
    bit            pv;
    int            tag;
  } exp_t;

  typedef struct {
    int       din;
    logic [7:0] t0, t1, t2;
    bit       v, pv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hw_accel_multi_line_buffer_if #(.DATA_WIDTH(PW), .CHANNELS(1), .NUM_TAPS(NT),
                                  .MAX_LINE_WORDS(MAXW)) bus ();

  hw_accel_multi_line_buffer #(.DATA_WIDTH(PW), .CHANNELS(1), .NUM_TAPS(NT),
                               .MAX_LINE_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];
  logic [TW-1:0] held;
  logic [7:0] px [16][16];
  int m_lw, m_line;
  logic [COL_W-1:0] m_col;
  logic [TW-1:0] obs_taps [16];
  bit obs_v [16];
  bit obs_pv [16];
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int eff_lw(input int lw);
    return (lw == 0 || lw > int'(MAXW)) ? int'(MAXW) : lw;
  endfunction

  task automatic model_accept(input bit s, input bit e, input int lw, input logic [7:0] d,
                              input int tag);
    exp_t x;
    x.active = e; x.taps = '0; x.v = 1'b0; x.pv = 1'b0; x.tag = tag;
    if (s) begin m_lw = eff_lw(lw); m_line = 0; m_col = '0; end
    if (e) begin
      px[m_line][m_col] = d;
      for (int k = 0; k < int'(NT); k++) begin
        if (m_line >= k) x.taps[k*PW +: PW] = px[m_line-k][m_col];
        else             x.taps[k*PW +: PW] = REP ? px[0][m_col] : 8'h00;
      end
      x.v  = (m_line >= int'(MM));
      x.pv = (m_line >= int'(MM/2));
      if (int'(m_col) == m_lw - 1) begin m_col = '0; m_line++; end
      else m_col = m_col + COL_W'(1);
    end
    q.push_back(x);
  endtask

  task automatic check_idle();
    chk("idle_valid", 32'(bus.dout_valid), 32'd0);
    chk("idle_padded_valid", 32'(bus.dout_padded_valid), 32'd0);
    chk("idle_taps_hold", 32'(bus.dout_taps), 32'(held));
  endtask

  task automatic step(input bit r, input bit s, input bit e, input int lw,
                      input logic [7:0] d, input int tag);
    exp_t x;
    @(negedge clk);
    rst = r; bus.sof = s; bus.en = e; bus.line_words = LWORDS_W'(lw); bus.din = d;
    if (!r) model_accept(s, e, lw, d, tag);
    @(posedge clk); #1;
    if (r) begin
      q.delete();
      held = '0; m_lw = int'(MAXW); m_line = 0; m_col = '0;
      chk("rst_taps", 32'(bus.dout_taps), 32'd0);
      chk("rst_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_padded_valid", 32'(bus.dout_padded_valid), 32'd0);
    end else if (q.size() >= 2) begin
      x = q.pop_front();
      if (x.active) begin
        chk("taps", 32'(bus.dout_taps), 32'(x.taps));
        chk("valid", 32'(bus.dout_valid), 32'(x.v));
        chk("padded_valid", 32'(bus.dout_padded_valid), 32'(x.pv));
        held = x.taps;
        if (x.tag >= 0 && x.tag < 16) begin
          obs_taps[x.tag] = bus.dout_taps;
          obs_v[x.tag]    = bus.dout_valid;
          obs_pv[x.tag]   = bus.dout_padded_valid;
        end
      end else begin
        check_idle();
      end
    end else begin
      check_idle();
    end
  endtask

  initial begin
    // Hand-derived taps for line_words=4, din=0..15 (border value depends on build)
    tbl[0] = '{din: 0,  t0: 0,  t1: 0,             t2: 0,             v: 0, pv: 0};
    tbl[1] = '{din: 3,  t0: 3,  t1: REP ? 3 : 0,   t2: REP ? 3 : 0,   v: 0, pv: 0};
    tbl[2] = '{din: 4,  t0: 4,  t1: 0,             t2: 0,             v: 0, pv: 1};
    tbl[3] = '{din: 5,  t0: 5,  t1: 1,             t2: REP ? 1 : 0,   v: 0, pv: 1};
    tbl[4] = '{din: 7,  t0: 7,  t1: 3,             t2: REP ? 3 : 0,   v: 0, pv: 1};
    tbl[5] = '{din: 8,  t0: 8,  t1: 4,             t2: 0,             v: 1, pv: 1};
    tbl[6] = '{din: 9,  t0: 9,  t1: 5,             t2: 1,             v: 1, pv: 1};
    tbl[7] = '{din: 15, t0: 15, t1: 11,            t2: 7,             v: 1, pv: 1};
    for (int i = 0; i < 16; i++) begin obs_taps[i] = 'x; obs_v[i] = 1'bx; obs_pv[i] = 1'bx; end

    bus.sof = 1'b0; bus.en = 1'b0; bus.line_words = '0; bus.din = '0;
    held = '0; m_lw = int'(MAXW); m_line = 0; m_col = '0;

    step(1, 0, 0, 0, 0, -1);
    step(1, 0, 0, 0, 0, -1);

    // Continuous frame, width 4
    step(0, 1, 0, 4, 0, -1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 4, 8'(i), i);
    step(0, 0, 0, 4, 0, -1);
    step(0, 0, 0, 4, 0, -1);

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl_tap0_d%0d", tbl[i].din), 32'(obs_taps[tbl[i].din][7:0]),   32'(tbl[i].t0));
      chk($sformatf("tbl_tap1_d%0d", tbl[i].din), 32'(obs_taps[tbl[i].din][15:8]),  32'(tbl[i].t1));
      chk($sformatf("tbl_tap2_d%0d", tbl[i].din), 32'(obs_taps[tbl[i].din][23:16]), 32'(tbl[i].t2));
      chk($sformatf("tbl_valid_d%0d", tbl[i].din), 32'(obs_v[tbl[i].din]),  32'(tbl[i].v));
      chk($sformatf("tbl_pvalid_d%0d", tbl[i].din), 32'(obs_pv[tbl[i].din]), 32'(tbl[i].pv));
    end

    // en toggling every cycle over 3 lines
    step(0, 1, 0, 4, 0, -1);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 4, 8'(i), -1);
      step(0, 0, 0, 4, 8'hAA, -1);
    end
    step(0, 0, 0, 4, 0, -1);

    // Partial width-4 frame, then sof+en restarting with width 6
    step(0, 1, 0, 4, 0, -1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4, 8'($urandom_range(0, 255)), -1);
    step(0, 1, 1, 6, 8'($urandom_range(0, 255)), -1);
    for (int i = 0; i < 23; i++) step(0, 0, 1, 6, 8'($urandom_range(0, 255)), -1);
    step(0, 0, 0, 6, 0, -1);
    step(0, 0, 0, 6, 0, -1);

    // One-pixel lines: every pixel is a line end
    step(0, 1, 1, 1, 8'h11, -1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'($urandom_range(0, 255)), -1);
    step(0, 0, 0, 1, 0, -1);

    // Out-of-range widths fall back to the maximum
    step(0, 1, 0, 2000, 0, -1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 2000, 8'($urandom_range(0, 255)), -1);
    step(0, 1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'($urandom_range(0, 255)), -1);
    step(0, 0, 0, 0, 0, -1);

    // Reset at column 2 of line 2, then a fresh fill
    step(0, 1, 0, 4, 0, -1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 4, 8'($urandom_range(0, 255)), -1);
    step(1, 0, 1, 4, 8'h5A, -1);
    step(0, 0, 0, 4, 0, -1);
    step(0, 1, 0, 4, 0, -1);
    for (int i = 0; i < 14; i++) step(0, 0, 1, 4, 8'($urandom_range(0, 255)), -1);
    step(0, 0, 0, 4, 0, -1);
    step(0, 0, 0, 4, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
